// File: rtl/tqvp_htfab_sdm_dac_pkg.sv
// Shared constants for the sigma-delta DAC peripheral.
// Holds register addresses, CTRL/STATUS bit positions, FIFO sizing,
// reset values and the STATUS packing helper.
package tqvp_htfab_sdm_dac_pkg;

  // Register map
  localparam logic [3:0] ADDR_DATA   = 4'd0;
  localparam logic [3:0] ADDR_RATE_L = 4'd1;
  localparam logic [3:0] ADDR_RATE_H = 4'd2;
  localparam logic [3:0] ADDR_CTRL   = 4'd3;
  localparam logic [3:0] ADDR_LEVELB = 4'd4;
  localparam logic [3:0] ADDR_CUR    = 4'd5;

  // CTRL bit positions (CLR and FLUSH are write-1 pulses, never stored)
  localparam int CTRL_EN_A  = 0;
  localparam int CTRL_HOLD  = 1;
  localparam int CTRL_CLR   = 2;
  localparam int CTRL_FLUSH = 3;
  localparam int CTRL_EN_B  = 4;

  // STATUS bit positions
  localparam int ST_EMPTY   = 0;
  localparam int ST_FULL    = 1;
  localparam int ST_OVF     = 2;
  localparam int ST_UDF     = 3;
  localparam int ST_CNT_LSB = 4;

  // FIFO sizing
  localparam int         FIFO_DEPTH      = 4;
  localparam logic [2:0] FIFO_FULL_COUNT = 3'd4;

  // Reset values
  localparam logic [15:0] RATE_RST   = 16'h00FF;
  localparam logic [7:0]  LEVELB_RST = 8'h80;

  // Assemble the STATUS byte from the FIFO occupancy and sticky flags.
  function automatic logic [7:0] pack_status(input logic [2:0] count,
                                             input logic       udf,
                                             input logic       ovf);
    return {1'b0, count, udf, ovf,
            (count == FIFO_FULL_COUNT), (count == 3'd0)};
  endfunction

endpackage

// File: rtl/tqvp_htfab_sdm_dac_if.sv
// TinyQV peripheral register bus.
// address    : register select
// data_write : single-cycle write strobe
// data_in    : write data, valid with data_write
// data_out   : combinational read data for the selected address
interface tqvp_htfab_sdm_dac_if;
  logic [3:0] address;
  logic       data_write;
  logic [7:0] data_in;
  logic [7:0] data_out;

  modport master (output address, output data_write, output data_in,
                  input data_out);
  modport slave  (input address, input data_write, input data_in,
                  output data_out);
endinterface

// File: rtl/tqvp_htfab_sdm_dac_sdm_mod1.sv
// First-order sigma-delta modulator.
// clk/rst : clock and synchronous active-high reset
// en      : run when high; when low the accumulator and output are cleared
// sample  : 8-bit level; output one-density is sample/256
// out     : registered bitstream (carry out of the accumulator)
module sdm_mod1 (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [7:0] sample,
  output logic       out
);

  logic [7:0] acc;
  logic [8:0] acc9;

  assign acc9 = {1'b0, acc} + {1'b0, sample};

  // Accumulate the sample and emit the carry as the output bit.
  always_ff @(posedge clk) begin
    if (rst || !en) begin
      acc <= 8'd0;
      out <= 1'b0;
    end else begin
      acc <= acc9[7:0];
      out <= acc9[8];
    end
  end

endmodule

// File: rtl/tqvp_htfab_sdm_dac.sv
// Sigma-delta DAC peripheral for the TinyQV bus.
// Software pushes 8-bit samples into a 4-deep FIFO; a programmable rate
// timer pops one per period into modulator A. Modulator B plays a static
// level.
// clk, rst : clock, synchronous active-high reset
// ui_in    : unused input PMOD
// uo_out   : [1] channel A bitstream, [2] sample tick, [3] channel B
//            bitstream, other bits 0
// bus      : register bus (slave side)
module tqvp_htfab_sdm_dac
  import tqvp_htfab_sdm_dac_pkg::*;
(
  input  logic                      clk,
  input  logic                      rst,
  input  logic [7:0]                ui_in,
  output logic [7:0]                uo_out,
  tqvp_htfab_sdm_dac_if.slave       bus
);

  // Register state
  logic [15:0] rate;
  logic [15:0] timer;
  logic        en_a;
  logic        hold;
  logic        en_b;
  logic [7:0]  level_b;
  logic [7:0]  cur;
  logic        ovf;
  logic        udf;

  // FIFO state
  logic [7:0]  mem [FIFO_DEPTH];
  logic [1:0]  wr_ptr;
  logic [1:0]  rd_ptr;
  logic [2:0]  count;

  // Decoded strobes
  logic wr_data, wr_rate_l, wr_rate_h, wr_ctrl, wr_levelb;
  logic tick, empty, full, pop, push_ok, ovf_set, udf_set, clr, flush;
  logic out_a, out_b;
  logic [7:0] rd_data;

  // The input PMOD is not used by this peripheral.
  logic unused_ui;
  assign unused_ui = &{1'b0, ui_in};

  assign wr_data   = bus.data_write && (bus.address == ADDR_DATA);
  assign wr_rate_l = bus.data_write && (bus.address == ADDR_RATE_L);
  assign wr_rate_h = bus.data_write && (bus.address == ADDR_RATE_H);
  assign wr_ctrl   = bus.data_write && (bus.address == ADDR_CTRL);
  assign wr_levelb = bus.data_write && (bus.address == ADDR_LEVELB);

  assign clr   = wr_ctrl && bus.data_in[CTRL_CLR];
  assign flush = wr_ctrl && bus.data_in[CTRL_FLUSH];

  assign tick  = en_a && (timer == 16'd0);
  assign empty = (count == 3'd0);
  assign full  = (count == FIFO_FULL_COUNT);
  assign pop   = tick && !empty;
  // A push into a full FIFO still lands when a pop frees a slot that cycle.
  assign push_ok = wr_data && (!full || pop);
  assign ovf_set = wr_data && full && !pop;
  assign udf_set = tick && empty;

  // Control and level registers written from the bus.
  always_ff @(posedge clk) begin
    if (rst) begin
      rate    <= RATE_RST;
      en_a    <= 1'b0;
      hold    <= 1'b0;
      en_b    <= 1'b0;
      level_b <= LEVELB_RST;
    end else begin
      if (wr_rate_l) rate[7:0]  <= bus.data_in;
      if (wr_rate_h) rate[15:8] <= bus.data_in;
      if (wr_ctrl) begin
        en_a <= bus.data_in[CTRL_EN_A];
        hold <= bus.data_in[CTRL_HOLD];
        en_b <= bus.data_in[CTRL_EN_B];
      end
      if (wr_levelb) level_b <= bus.data_in;
    end
  end

  // Sample-rate timer: parked at RATE while disabled, reloads on tick.
  always_ff @(posedge clk) begin
    if (rst) begin
      timer <= RATE_RST;
    end else if (!en_a || (timer == 16'd0)) begin
      timer <= rate;
    end else begin
      timer <= timer - 16'd1;
    end
  end

  // FIFO pointers and occupancy; flush discards everything queued.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= 2'd0;
      rd_ptr <= 2'd0;
      count  <= 3'd0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 2'd1;
      if (pop)     rd_ptr <= rd_ptr + 2'd1;
      count <= count + {2'b00, push_ok} - {2'b00, pop};
    end
  end

  // FIFO storage; contents are don't-care outside the occupied slots.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr] <= bus.data_in;
    end
  end

  // Current channel A sample: loaded on tick, or zeroed on underflow
  // unless hold is set.
  always_ff @(posedge clk) begin
    if (rst) begin
      cur <= 8'h00;
    end else if (pop) begin
      cur <= mem[rd_ptr];
    end else if (udf_set && !hold) begin
      cur <= 8'h00;
    end
  end

  // Sticky flags; a set in the same cycle as a clear wins.
  always_ff @(posedge clk) begin
    if (rst) begin
      ovf <= 1'b0;
      udf <= 1'b0;
    end else begin
      ovf <= ovf_set || (ovf && !clr);
      udf <= udf_set || (udf && !clr);
    end
  end

  sdm_mod1 u_mod_a (
    .clk    (clk),
    .rst    (rst),
    .en     (en_a),
    .sample (cur),
    .out    (out_a)
  );

  sdm_mod1 u_mod_b (
    .clk    (clk),
    .rst    (rst),
    .en     (en_b),
    .sample (level_b),
    .out    (out_b)
  );

  // Read mux, combinational on address.
  always_comb begin
    rd_data = 8'h00;
    case (bus.address)
      ADDR_DATA:   rd_data = pack_status(count, udf, ovf);
      ADDR_RATE_L: rd_data = rate[7:0];
      ADDR_RATE_H: rd_data = rate[15:8];
      ADDR_CTRL:   rd_data = {3'b000, en_b, 2'b00, hold, en_a};
      ADDR_LEVELB: rd_data = level_b;
      ADDR_CUR:    rd_data = cur;
      default:     rd_data = 8'h00;
    endcase
  end

  assign bus.data_out = rd_data;
  assign uo_out = {4'b0000, out_b, tick, out_a, 1'b0};

endmodule

// File: tb/tb_tqvp_htfab_sdm_dac.sv
// Self-checking bench for tqvp_htfab_sdm_dac. Samples pushed into the DUT
// FIFO are mirrored into a scoreboard queue and compared against the
// current-sample register after each tick.
module tb_tqvp_htfab_sdm_dac;
  import tqvp_htfab_sdm_dac_pkg::*;

  logic       clk;
  logic       rst;
  logic [7:0] ui_in;
  logic [7:0] uo_out;
  int         n_checks;
  int         n_pass;
  logic [7:0] sb_q [$];
  logic [7:0] v;
  int         ones;

  tqvp_htfab_sdm_dac_if bif ();

  tqvp_htfab_sdm_dac dut (
    .clk    (clk),
    .rst    (rst),
    .ui_in  (ui_in),
    .uo_out (uo_out),
    .bus    (bif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [15:0] obs,
                          input logic [15:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic sb_expect(input string tag, input logic [7:0] obs);
    logic [7:0] exp;
    if (sb_q.size() == 0) begin
      check_eq({tag, "_sb_empty"}, 16'(obs), 16'hFFFF);
    end else begin
      exp = sb_q.pop_front();
      check_eq(tag, 16'(obs), 16'(exp));
    end
  endtask

  // Called at a falling edge; the write is sampled on the next rising edge
  // and the task returns at the following falling edge.
  task automatic bus_write(input logic [3:0] a, input logic [7:0] d);
    bif.address    = a;
    bif.data_in    = d;
    bif.data_write = 1'b1;
    @(negedge clk);
    bif.data_write = 1'b0;
  endtask

  task automatic bus_read(input logic [3:0] a, output logic [7:0] d);
    bif.address = a;
    #1;
    d = bif.data_out;
  endtask

  task automatic push_sample(input logic [7:0] d, input bit expect_kept);
    bus_write(ADDR_DATA, d);
    if (expect_kept) sb_q.push_back(d);
  endtask

  task automatic wait_tick(input string tag);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (uo_out[2] !== 1'b1 && n < 64);
    check_eq(tag, 16'(uo_out[2]), 16'd1);
  endtask

  initial begin
    n_checks       = 0;
    n_pass         = 0;
    ui_in          = 8'h00;
    rst            = 1'b1;
    bif.address    = 4'd0;
    bif.data_write = 1'b0;
    bif.data_in    = 8'h00;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Reset state
    check_eq("rst_uo_out", 16'(uo_out), 16'h0000);
    bus_read(ADDR_DATA, v);   check_eq("rst_status", 16'(v), 16'h0001);
    bus_read(ADDR_CUR, v);    check_eq("rst_cur", 16'(v), 16'h0000);
    bus_read(ADDR_RATE_L, v); check_eq("rst_rate_l", 16'(v), 16'h00FF);
    bus_read(ADDR_RATE_H, v); check_eq("rst_rate_h", 16'(v), 16'h0000);
    bus_read(ADDR_LEVELB, v); check_eq("rst_levelb", 16'(v), 16'h0080);
    bus_read(ADDR_CTRL, v);   check_eq("rst_ctrl", 16'(v), 16'h0000);
    @(negedge clk);

    // Unlisted address: write ignored, read 0
    bus_write(4'd9, 8'h55);
    bus_read(4'd9, v); check_eq("unlisted_rd", 16'(v), 16'h0000);
    @(negedge clk);

    // RATE=3, one sample 0x40, enable with hold: tick 3 edges after enable
    bus_write(ADDR_RATE_L, 8'h03);
    push_sample(8'h40, 1'b1);
    bus_write(ADDR_CTRL, 8'h03);
    for (int k = 0; k < 4; k++) begin
      check_eq($sformatf("t2_tick%0d", k), 16'(uo_out[2]), 16'((k == 3) ? 1 : 0));
      if (k < 3) @(negedge clk);
    end
    bus_read(ADDR_CUR, v); check_eq("t2_cur_before", 16'(v), 16'h0000);
    @(negedge clk);
    bus_read(ADDR_CUR, v); sb_expect("t2_cur", v);
    @(negedge clk);
    ones = 0;
    for (int i = 0; i < 256; i++) begin
      if (i < 8) check_eq($sformatf("t2_bit%0d", i), 16'(uo_out[1]), 16'((i % 4 == 3) ? 1 : 0));
      ones += int'(uo_out[1]);
      @(negedge clk);
    end
    check_eq("t2_ones_256", 16'(ones), 16'd64);

    // Stop, clear and flush; current sample survives the flush
    bus_write(ADDR_CTRL, 8'h00);
    bus_write(ADDR_CTRL, 8'h0C);
    bus_read(ADDR_DATA, v); check_eq("t3_flushed", 16'(v), 16'h0001);
    bus_read(ADDR_CUR, v);  check_eq("t3_cur_kept", 16'(v), 16'h0040);
    @(negedge clk);

    // Five pushes into a 4-deep FIFO: last one dropped
    push_sample(8'h11, 1'b1);
    push_sample(8'h22, 1'b1);
    push_sample(8'h33, 1'b1);
    push_sample(8'h44, 1'b1);
    push_sample(8'h55, 1'b0);
    bus_read(ADDR_DATA, v); check_eq("t3_status_full", 16'(v), 16'h0046);
    @(negedge clk);
    bus_write(ADDR_CTRL, 8'h03);
    for (int i = 0; i < 4; i++) begin
      wait_tick("t3_tick");
      @(negedge clk);
      bus_read(ADDR_CUR, v); sb_expect($sformatf("t3_pop%0d", i), v);
    end

    // Underflow with hold=1 keeps the sample
    wait_tick("t4_udf_tick");
    @(negedge clk);
    bus_read(ADDR_CUR, v);  check_eq("t4_hold_cur", 16'(v), 16'h0044);
    bus_read(ADDR_DATA, v); check_eq("t4_udf_set", 16'(v[ST_UDF]), 16'd1);
    bus_write(ADDR_CTRL, 8'h06);
    bus_read(ADDR_DATA, v); check_eq("t4_udf_clr", 16'(v[ST_UDF]), 16'd0);
    bus_read(ADDR_CTRL, v); check_eq("t4_ctrl_rd", 16'(v), 16'h0002);
    @(negedge clk);

    // Underflow with hold=0 zeroes the sample
    bus_write(ADDR_CTRL, 8'h01);
    wait_tick("t4b_tick");
    @(negedge clk);
    bus_read(ADDR_CUR, v);  check_eq("t4b_zero_cur", 16'(v), 16'h0000);
    bus_read(ADDR_DATA, v); check_eq("t4b_udf_set", 16'(v[ST_UDF]), 16'd1);
    @(negedge clk);

    // Channel B static level 0xFF: exactly one zero per 256 cycles
    bus_write(ADDR_CTRL, 8'h00);
    bus_write(ADDR_LEVELB, 8'hFF);
    bus_write(ADDR_CTRL, 8'h10);
    repeat (3) @(negedge clk);
    ones = 0;
    for (int i = 0; i < 256; i++) begin
      ones += int'(uo_out[3]);
      @(negedge clk);
    end
    check_eq("t5_b_ff_zeros", 16'(256 - ones), 16'd1);
    bus_write(ADDR_LEVELB, 8'h00);
    repeat (2) @(negedge clk);
    ones = 0;
    for (int i = 0; i < 256; i++) begin
      ones += int'(uo_out[3]);
      @(negedge clk);
    end
    check_eq("t5_b_00_ones", 16'(ones), 16'd0);

    // Full FIFO, RATE=0, push on the first tick cycle
    bus_write(ADDR_CTRL, 8'h0C);
    bus_write(ADDR_RATE_L, 8'h00);
    push_sample(8'hA1, 1'b1);
    push_sample(8'hA2, 1'b1);
    push_sample(8'hA3, 1'b1);
    push_sample(8'hA4, 1'b1);
    bus_read(ADDR_DATA, v); check_eq("t6_full", 16'(v), 16'h0042);
    @(negedge clk);
    bus_write(ADDR_CTRL, 8'h01);
    check_eq("t6_tick_now", 16'(uo_out[2]), 16'd1);
    push_sample(8'hA5, 1'b1);
    bus_read(ADDR_DATA, v); check_eq("t6_status_after", 16'(v), 16'h0042);
    for (int i = 0; i < 5; i++) begin
      bus_read(ADDR_CUR, v); sb_expect($sformatf("t6_pop%0d", i), v);
      @(negedge clk);
    end
    check_eq("t6_sb_drained", 16'(sb_q.size()), 16'd0);

    // Reset mid-stream
    bus_write(ADDR_CTRL, 8'h00);
    push_sample(8'h99, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_eq("rst2_uo_out", 16'(uo_out), 16'h0000);
    bus_read(ADDR_DATA, v);   check_eq("rst2_status", 16'(v), 16'h0001);
    bus_read(ADDR_RATE_L, v); check_eq("rst2_rate_l", 16'(v), 16'h00FF);
    bus_read(ADDR_LEVELB, v); check_eq("rst2_levelb", 16'(v), 16'h0080);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
